// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain: DEPTH stages of WIDTH-bit payload with
// bubble collapse, per-stage flush, registered occupancy and a saturating stall counter.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [DEPTH-1:0]             flush_mask,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  input  logic                         stall_clr
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH-1:0] eff_valid;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] valid_d;
  logic             stall;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(vec[i]);
    end
    return cnt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

  // Ready ripples from the output back to the input; a local accumulator
  // keeps the chain free of bit-to-bit feedback within one vector.
  always_comb begin
    logic rdy;
    eff_valid = valid_q & ~flush_mask;
    load      = '0;
    rdy       = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy     = ~eff_valid[i] | rdy;
      load[i] = rdy;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = eff_valid[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  // A stage that does not load is necessarily live and unflushed, so holding
  // valid_q there is equivalent to holding its effective valid.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (load[i]) begin
        valid_d[i] = src_valid[i];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = eff_valid[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign stall     = out_valid & ~out_ready;

  // ---- stage registers: control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_d;
      occupancy <= popcount(valid_d);
    end
  end

  // ---- stage registers: payload (only captured with a live source) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i] && src_valid[i]) begin
          data_q[i] <= src_data[i];
        end
      end
    end
  end

  // ---- stall counter: clear wins over increment ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
